gie_guard: RTL and testbench

Parametrised successor to the single-region interrupt-disable detector in the hw-mod monitor set. It watches the core PC and the GIE bit against up to NUM_REGIONS trusted code regions, and enforces four rules. Interrupts may only be disabled or enabled from inside a trusted region. Only the region that disabled interrupts may re-enable them. Interrupts may not stay disabled longer than a bounded cycle count. Any violation drives a registered platform-reset request plus a sticky cause code until the core re-enters the reset handler.

---
 rtl/gie_guard_pkg.sv | 28 ++
 rtl/gie_region_match.sv | 38 +++
 rtl/gie_guard.sv | 140 ++++++++++++++
 tb/tb_gie_guard.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gie_guard_pkg.sv
// Shared encodings for the GIE guard: FSM states, violation cause codes and width helpers.
// Pure declarations; no logic, no latency.
package gie_guard_pkg;

  localparam int CAUSE_W = 3;

  localparam logic [1:0] ST_ON   = 2'b00;
  localparam logic [1:0] ST_OFF  = 2'b01;
  localparam logic [1:0] ST_KILL = 2'b10;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE        = 3'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_POR         = 3'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_EN_OUTSIDE  = 3'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_DIS_OUTSIDE = 3'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_EN_FOREIGN  = 3'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT     = 3'd5;

  // Bit width needed to index n items, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit width needed to hold the value n, never below one bit.
  function automatic int val_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/gie_region_match.sv
// Combinational trusted-region decoder: flags whether pc lies in any region and which one.
// Zero latency; lowest region index wins on overlap; no flow control.
module gie_region_match
  import gie_guard_pkg::*;
#(
  parameter int PC_W        = 16,
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*PC_W-1:0] REGION_BASE = {16'h0030, 16'h0010},
  parameter logic [NUM_REGIONS*PC_W-1:0] REGION_SIZE = {16'h0020, 16'h0010},
  localparam int IDX_W = idx_width(NUM_REGIONS)
) (
  input  logic [PC_W-1:0]  pc,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx
);

  logic [NUM_REGIONS-1:0] match;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_rgn
    localparam logic [PC_W-1:0] BASE = REGION_BASE[g*PC_W +: PC_W];
    localparam logic [PC_W-1:0] SIZE = REGION_SIZE[g*PC_W +: PC_W];
    // Last word address kept one bit wider so a region at the top of memory cannot wrap.
    localparam logic [PC_W:0]   LAST = {1'b0, BASE} + {1'b0, SIZE} - (PC_W+1)'(2);
    assign match[g] = (pc >= BASE) && ({1'b0, pc} <= LAST);
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/gie_guard.sv
// Watches PC and GIE against trusted regions; any illegal GIE change or overlong disable requests platform reset.
// Outputs registered, one cycle after the sampled violation; no backpressure, async reset forces KILL/POR.
module gie_guard
  import gie_guard_pkg::*;
#(
  parameter int PC_W        = 16,
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*PC_W-1:0] REGION_BASE = {16'h0030, 16'h0010},
  parameter logic [NUM_REGIONS*PC_W-1:0] REGION_SIZE = {16'h0020, 16'h0010},
  parameter logic [PC_W-1:0] RESET_HANDLER = 16'h0000,
  parameter int MAX_OFF_CYCLES = 256
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PC_W-1:0]    pc,
  input  logic               gie,
  output logic               reset,
  output logic [CAUSE_W-1:0] cause,
  output logic [1:0]         state
);

  localparam int IDX_W = idx_width(NUM_REGIONS);
  localparam int CNT_W = val_width(MAX_OFF_CYCLES);
  localparam bit TO_EN = (MAX_OFF_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? MAX_OFF_CYCLES - 1 : 0);

  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  logic [1:0]         state_q, state_d;
  logic               reset_q, reset_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [IDX_W-1:0]   owner_idx_q, owner_idx_d;
  logic               owner_vld_q, owner_vld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  gie_region_match #(
    .PC_W        (PC_W),
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_SIZE (REGION_SIZE)
  ) u_match (
    .pc      (pc),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  always_comb begin
    state_d     = state_q;
    reset_d     = reset_q;
    cause_d     = cause_q;
    owner_idx_d = owner_idx_q;
    owner_vld_d = owner_vld_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_KILL: begin
        if (pc == RESET_HANDLER && !gie) begin
          // Fresh boot: no owner yet, so any trusted region may do the first enable.
          state_d     = ST_OFF;
          reset_d     = 1'b0;
          cause_d     = CAUSE_NONE;
          cnt_d       = '0;
          owner_vld_d = 1'b0;
          owner_idx_d = '0;
        end else begin
          reset_d = 1'b1;
        end
      end

      ST_OFF: begin
        if (gie) begin
          if (!hit) begin
            state_d = ST_KILL;
            reset_d = 1'b1;
            cause_d = CAUSE_EN_OUTSIDE;
          end else if (owner_vld_q && hit_idx != owner_idx_q) begin
            state_d = ST_KILL;
            reset_d = 1'b1;
            cause_d = CAUSE_EN_FOREIGN;
          end else begin
            state_d = ST_ON;
            cnt_d   = '0;
          end
        end else if (owner_vld_q) begin
          if (TO_EN && cnt_q == CNT_LAST) begin
            state_d = ST_KILL;
            reset_d = 1'b1;
            cause_d = CAUSE_TIMEOUT;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_ON: begin
        if (!gie) begin
          if (!hit) begin
            state_d = ST_KILL;
            reset_d = 1'b1;
            cause_d = CAUSE_DIS_OUTSIDE;
          end else begin
            state_d     = ST_OFF;
            owner_idx_d = hit_idx;
            owner_vld_d = 1'b1;
            cnt_d       = '0;
          end
        end
      end

      default: begin
        state_d = ST_KILL;
        reset_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_KILL;
      reset_q     <= 1'b1;
      cause_q     <= CAUSE_POR;
      owner_idx_q <= '0;
      owner_vld_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      reset_q     <= reset_d;
      cause_q     <= cause_d;
      owner_idx_q <= owner_idx_d;
      owner_vld_q <= owner_vld_d;
      cnt_q       <= cnt_d;
    end
  end

  assign reset = reset_q;
  assign cause = cause_q;
  assign state = state_q;

endmodule

// File: tb/tb_gie_guard.sv
// Randomized plus directed scoreboard bench for gie_guard against a rule-level reference model.
module tb_gie_guard;

  localparam int MAX_OFF = 4;

  logic        clk;
  logic        reset_n;
  logic [15:0] pc;
  logic        gie;
  logic        reset;
  logic [2:0]  cause;
  logic [1:0]  state;

  gie_guard #(
    .PC_W           (16),
    .NUM_REGIONS    (2),
    .REGION_BASE    ({16'h0030, 16'h0010}),
    .REGION_SIZE    ({16'h0020, 16'h0010}),
    .RESET_HANDLER  (16'h0000),
    .MAX_OFF_CYCLES (MAX_OFF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pc      (pc),
    .gie     (gie),
    .reset   (reset),
    .cause   (cause),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] cause;
    logic [1:0] st;
    int         step;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step     = 0;

  // Reference model: plain booleans and counts, following the guard's rules directly.
  bit m_killed;
  bit m_int_on;
  int m_owner;     // -1 when no region has disabled interrupts since boot
  int m_off_len;   // cycles with GIE low since the owning disable
  int m_cause;

  function automatic int region_of(input int p);
    if (p >= 16'h0010 && p <= 16'h0010 + 16'h0010 - 2) return 0;
    if (p >= 16'h0030 && p <= 16'h0030 + 16'h0020 - 2) return 1;
    return -1;
  endfunction

  function automatic void model_por();
    m_killed  = 1'b1;
    m_int_on  = 1'b0;
    m_owner   = -1;
    m_off_len = 0;
    m_cause   = 1;
  endfunction

  function automatic void model_kill(input int c);
    m_killed = 1'b1;
    m_cause  = c;
  endfunction

  function automatic void model_step(input int p, input bit g);
    int r;
    r = region_of(p);
    if (m_killed) begin
      if (p == 0 && !g) begin
        m_killed = 1'b0;
        m_int_on = 1'b0;
        m_owner  = -1;
        m_cause  = 0;
      end
    end else if (!m_int_on) begin
      if (g) begin
        if (r < 0)                         model_kill(2);
        else if (m_owner >= 0 && r != m_owner) model_kill(4);
        else                               m_int_on = 1'b1;
      end else if (m_owner >= 0) begin
        m_off_len++;
        if (MAX_OFF != 0 && m_off_len >= MAX_OFF) model_kill(5);
      end
    end else if (!g) begin
      if (r < 0) model_kill(3);
      else begin
        m_int_on  = 1'b0;
        m_owner   = r;
        m_off_len = 0;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", name, step, act, exp_v);
    end
  endtask

  task automatic cycle(input logic [15:0] p, input logic g);
    exp_t e;
    @(negedge clk);
    pc  = p;
    gie = g;
    step++;
    model_step(int'(p), g);
    e.rst   = m_killed;
    e.cause = 3'(m_cause);
    e.st    = m_killed ? 2'b10 : (m_int_on ? 2'b00 : 2'b01);
    e.step  = step;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so each pushed expectation is compared just after the next edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (reset !== e.rst || cause !== e.cause || state !== e.st) begin
          n_errors++;
          $display("FAIL scoreboard step %0d: got reset=%0b cause=%0d state=%0d, expected reset=%0b cause=%0d state=%0d",
                   e.step, reset, cause, state, e.rst, e.cause, e.st);
        end
      end
    end
  end

  function automatic logic [15:0] rand_pc();
    case ($urandom_range(0, 9))
      0: return 16'h0000;
      1: return 16'h000F;
      2: return 16'h0010;
      3: return 16'h001E;
      4: return 16'h001F;
      5: return 16'h0030;
      6: return 16'h004E;
      7: return 16'h004F;
      8: return 16'($urandom_range(16'h0030, 16'h004E));
      default: return 16'($urandom_range(0, 16'hFFFF));
    endcase
  endfunction

  task automatic boot();
    cycle(16'h0000, 1'b0);
  endtask

  initial begin
    logic g;
    reset_n = 1'b0;
    pc      = 16'h0000;
    gie     = 1'b1;
    model_por();
    #12;
    chk("por_reset", 8'(reset), 8'd1);
    chk("por_cause", 8'(cause), 8'd1);
    chk("por_state", 8'(state), 8'd2);
    @(negedge clk);
    reset_n = 1'b1;
    // Not at the handler (gie high) so the guard must stay in KILL.
    cycle(16'h0000, 1'b1);

    // Boot release, then foreign-region enable.
    boot();
    cycle(16'h0014, 1'b1);
    cycle(16'h0018, 1'b0);
    cycle(16'h0034, 1'b1);

    // Disable outside any region, then recover.
    boot();
    cycle(16'h0014, 1'b1);
    cycle(16'h0100, 1'b0);
    cycle(16'h0000, 1'b0);

    // Timeout after exactly MAX_OFF edges of GIE low.
    cycle(16'h0014, 1'b1);
    cycle(16'h0012, 1'b0);
    repeat (MAX_OFF) cycle(16'h0012, 1'b0);
    // Owner re-enables on the would-be timeout edge: enable wins.
    boot();
    cycle(16'h0014, 1'b1);
    cycle(16'h0012, 1'b0);
    repeat (MAX_OFF - 1) cycle(16'h0012, 1'b0);
    cycle(16'h0014, 1'b1);
    cycle(16'h0014, 1'b1);

    // Enable outside, then a long boot-OFF hold with no owner.
    cycle(16'h0014, 1'b0);
    cycle(16'h0000, 1'b0);
    cycle(16'h0200, 1'b1);
    boot();
    repeat (1000) cycle(16'h0012, 1'b0);

    // Asynchronous reset between edges while in OFF.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 8'(reset), 8'd1);
    chk("async_cause", 8'(cause), 8'd1);
    chk("async_state", 8'(state), 8'd2);
    model_por();
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    boot();

    // Randomized traffic biased toward region edges and the reset handler.
    g = 1'b0;
    repeat (4000) begin
      if ($urandom_range(0, 3) == 0) g = ~g;
      cycle(rand_pc(), g);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
